// File: rtl/ahb_mem_slave.sv
// AHB-Lite word memory subordinate with programmable wait states and two-cycle ERROR.
// Define AHB_MEM_WRITE_EN to build the write port; otherwise every write is answered with ERROR.
module ahb_mem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int         AW          = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT   = 4'(WAIT_STATES);
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ  = 2'b11;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;

`ifdef AHB_MEM_WRITE_EN
  localparam bit WRITE_EN = 1'b1;
`else
  localparam bit WRITE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] cur_idx;
  logic          cur_write;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          legal;
  logic          addr_in_range;
  logic [AW-1:0] addr_idx;
  logic [AW-1:0] rd_idx;
  logic          commit;
  logic          fwd_hit;
  logic [31:0]   rd_word;

  // A data phase can only start while this slave is not stalling the bus.
  assign accept        = hsel & hready & hreadyout &
                         ((htrans == HTRANS_NSEQ) | (htrans == HTRANS_SEQ));
  assign addr_idx      = haddr[AW+1:2];
  assign addr_in_range = (haddr[31:AW+2] == '0);
  assign legal         = (hsize == HSIZE_WORD) & (haddr[1:0] == 2'b00) &
                         addr_in_range & (~hwrite | WRITE_EN);

  // Write commits at the edge that ends the DONE cycle; a read loading hrdata at
  // that same edge for the same word takes the write data instead of stale memory.
  assign commit  = WRITE_EN & (state == ST_DONE) & cur_write;
  assign rd_idx  = (state == ST_WAIT) ? cur_idx : addr_idx;
  assign fwd_hit = commit & (rd_idx == cur_idx);
  assign rd_word = fwd_hit ? hwdata : mem[rd_idx];

  // NOTE: the memory array has no reset; clearing it would turn the RAM into flops.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[cur_idx] <= hwdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      cur_idx   <= '0;
      cur_write <= 1'b0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          // Counter enters at WAIT_STATES, so WAIT lasts exactly WAIT_STATES cycles.
          if (wait_cnt <= 4'd1) begin
            wait_cnt  <= '0;
            state     <= ST_DONE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            if (!cur_write) begin
              hrdata <= rd_word;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_ERR1: begin
          state     <= ST_ERR2;
          hreadyout <= 1'b1;
          hresp     <= 1'b1;
        end

        default: begin
          // IDLE, DONE and ERR2 all end with hreadyout high, so a new transfer pipelines here.
          if (accept) begin
            cur_idx   <= addr_idx;
            cur_write <= hwrite;
            if (!legal) begin
              state     <= ST_ERR1;
              hreadyout <= 1'b0;
              hresp     <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state     <= ST_WAIT;
              wait_cnt  <= WAIT_INIT;
              hreadyout <= 1'b0;
              hresp     <= 1'b0;
            end else begin
              state     <= ST_DONE;
              hreadyout <= 1'b1;
              hresp     <= 1'b0;
              if (!hwrite) begin
                hrdata <= rd_word;
              end
            end
          end else begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Randomized bench for ahb_mem_slave: two instances (2 and 0 wait states) checked each cycle
// against a transaction-level model of data-phase length, response and memory contents.
module tb_ahb_mem_slave;

  localparam int DEPTH = 64;
  localparam int NI    = 2;

`ifdef AHB_MEM_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready_en;
  logic        hready    [NI];
  logic        hreadyout [NI];
  logic        hresp     [NI];
  logic [31:0] hrdata    [NI];

  always #5 clk = ~clk;

  assign hready[0] = hready_en & hreadyout[0];
  assign hready[1] = hready_en & hreadyout[1];

  ahb_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rstn(rstn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready[0]),
    .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
  );

  ahb_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rstn(rstn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready[1]),
    .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
  );

  // Reference model: one pending data phase per slave, described by its length and progress.
  bit          m_pend [NI];
  bit          m_err  [NI];
  bit          m_wr   [NI];
  bit          m_acc  [NI];
  int          m_cyc  [NI];
  int          m_len  [NI];
  int          m_idx  [NI];
  logic [31:0] m_rdata[NI];
  logic [31:0] m_mem  [NI][DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ws(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_ready(input int k);
    return !m_pend[k] || (m_cyc[k] == m_len[k] - 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_pend[k]  = 1'b0;
      m_err[k]   = 1'b0;
      m_wr[k]    = 1'b0;
      m_acc[k]   = 1'b0;
      m_cyc[k]   = 0;
      m_len[k]   = 0;
      m_idx[k]   = 0;
      m_rdata[k] = 32'h0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      bit          acc;
      bit          ill;
      logic [31:0] word;
      acc = hsel[k] && hready_en && exp_ready(k) && htrans[1];
      if (m_pend[k]) begin
        if (m_cyc[k] == m_len[k] - 1) begin
          if (m_wr[k] && !m_err[k]) m_mem[k][m_idx[k]] = hwdata;
          m_pend[k] = 1'b0;
        end else begin
          m_cyc[k]++;
          if (m_cyc[k] == m_len[k] - 1 && !m_err[k] && !m_wr[k]) m_rdata[k] = m_mem[k][m_idx[k]];
        end
      end
      if (acc) begin
        word = haddr >> 2;
        ill  = (hsize != 3'b010) || (haddr[1:0] != 2'b00) || (word >= 32'(DEPTH)) ||
               (hwrite && !WR_EN);
        m_pend[k] = 1'b1;
        m_err[k]  = ill;
        m_wr[k]   = hwrite;
        m_idx[k]  = ill ? 0 : int'(word);
        m_cyc[k]  = 0;
        m_len[k]  = ill ? 2 : ws(k) + 1;
        if (!ill && !hwrite && m_len[k] == 1) m_rdata[k] = m_mem[k][m_idx[k]];
      end
      m_acc[k] = acc;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("ws%0d hreadyout", ws(k)), 32'(hreadyout[k]), 32'(exp_ready(k)));
      check($sformatf("ws%0d hresp", ws(k)), 32'(hresp[k]), 32'(m_pend[k] && m_err[k]));
      check($sformatf("ws%0d hrdata", ws(k)), hrdata[k], m_rdata[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rstn) model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_bus();
    hsel      = 2'b00;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    hsize     = 3'b010;
    haddr     = 32'h0;
    hready_en = 1'b1;
  endtask

  task automatic preload(input int k, input int idx, input logic [31:0] v);
    m_mem[k][idx] = v;
    if (k == 0) u_ws2.mem[idx] = v;
    else        u_ws0.mem[idx] = v;
  endtask

  // Present a NONSEQ transfer to slave k and hold it until the model accepts it.
  task automatic issue(input int k, input logic [31:0] addr, input bit wr, input logic [2:0] size);
    hsel      = 2'(1 << k);
    haddr     = addr;
    hwrite    = wr;
    hsize     = size;
    htrans    = 2'b10;
    hready_en = 1'b1;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (m_acc[k]) break;
    end
  endtask

  task automatic drain();
    idle_bus();
    for (int n = 0; n < 20 && (m_pend[0] || m_pend[1]); n++) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected to finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ill_addr [3];
    logic [2:0]  ill_size [3];

    idle_bus();
    hwdata = 32'h0;
    rstn   = 1'b1;
    #1 rstn = 1'b0;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      preload(0, i, $urandom);
      preload(1, i, $urandom);
    end
    preload(0, 4, 32'hDEADBEEF);
    preload(1, 0, 32'h1);
    preload(1, 1, 32'h2);
    preload(1, 2, 32'h3);
    preload(1, 8, 32'h0BADF00D);
    preload(0, 12, 32'h12345678);
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      check("reset hreadyout", 32'(hreadyout[k]), 32'd1);
      check("reset hresp", 32'(hresp[k]), 32'd0);
      check("reset hrdata", hrdata[k], 32'h0);
    end
    rstn = 1'b1;
    cycle();

    // 2 wait states: read of 0x10 stalls two cycles then returns the preloaded word.
    issue(0, 32'h10, 1'b0, 3'b010);
    idle_bus();
    check("ws2 read wait1", 32'(hreadyout[0]), 32'd0);
    cycle();
    check("ws2 read wait2", 32'(hreadyout[0]), 32'd0);
    cycle();
    check("ws2 read ready", 32'(hreadyout[0]), 32'd1);
    check("ws2 read data", hrdata[0], 32'hDEADBEEF);
    drain();

    // 0 wait states: back-to-back reads stream one word per cycle.
    issue(1, 32'h0, 1'b0, 3'b010);
    check("ws0 stream0 data", hrdata[1], 32'h1);
    haddr  = 32'h4;
    htrans = 2'b11;
    cycle();
    check("ws0 stream1 ready", 32'(hreadyout[1]), 32'd1);
    check("ws0 stream1 data", hrdata[1], 32'h2);
    haddr = 32'h8;
    cycle();
    check("ws0 stream2 ready", 32'(hreadyout[1]), 32'd1);
    check("ws0 stream2 data", hrdata[1], 32'h3);
    drain();

    // Illegal transfers: misaligned, wrong size, beyond the top word.
    ill_addr = '{32'h2, 32'h10, 32'(DEPTH * 4)};
    ill_size = '{3'b010, 3'b000, 3'b010};
    for (int i = 0; i < 3; i++) begin
      issue(0, ill_addr[i], 1'b0, ill_size[i]);
      idle_bus();
      check($sformatf("err%0d c1 hresp", i), 32'(hresp[0]), 32'd1);
      check($sformatf("err%0d c1 hreadyout", i), 32'(hreadyout[0]), 32'd0);
      cycle();
      check($sformatf("err%0d c2 hresp", i), 32'(hresp[0]), 32'd1);
      check($sformatf("err%0d c2 hreadyout", i), 32'(hreadyout[0]), 32'd1);
      cycle();
      check($sformatf("err%0d after hresp", i), 32'(hresp[0]), 32'd0);
    end

    // Write immediately followed by a read of the same word.
    hwdata = 32'hCAFEF00D;
    issue(1, 32'h20, 1'b1, 3'b010);
    check("wr resp", 32'(hresp[1]), WR_EN ? 32'd0 : 32'd1);
    issue(1, 32'h20, 1'b0, 3'b010);
    drain();
    check("raw hrdata", hrdata[1], WR_EN ? 32'hCAFEF00D : 32'h0BADF00D);

    // IDLE and BUSY transfers never touch memory.
    hsel   = 2'b11;
    hwrite = 1'b1;
    haddr  = 32'h20;
    for (int i = 0; i < 4; i++) begin
      htrans = 2'(i % 2);
      hwdata = $urandom;
      cycle();
    end
    for (int k = 0; k < NI; k++) begin
      issue(k, 32'h20, 1'b0, 3'b010);
      drain();
      check($sformatf("ws%0d idle/busy untouched", ws(k)), hrdata[k], m_mem[k][8]);
    end

    // hready low during a NONSEQ address phase: nothing accepted.
    hsel      = 2'b01;
    haddr     = 32'h10;
    htrans    = 2'b10;
    hready_en = 1'b0;
    cycle();
    check("hready low ignored", 32'(hreadyout[0]), 32'd1);
    idle_bus();
    cycle();

    // Reset in the middle of WAIT drops the transfer; a pending write is never committed.
    hwdata = 32'hA5A55A5A;
    issue(0, 32'h30, WR_EN, 3'b010);
    check("pre-reset in wait", 32'(hreadyout[0]), 32'd0);
    rstn = 1'b0;
    #1;
    check("mid-wait reset hreadyout", 32'(hreadyout[0]), 32'd1);
    check("mid-wait reset hresp", 32'(hresp[0]), 32'd0);
    check("mid-wait reset hrdata", hrdata[0], 32'h0);
    model_reset();
    idle_bus();
    @(negedge clk);
    rstn = 1'b1;
    cycle();
    issue(0, 32'h30, 1'b0, 3'b010);
    drain();
    check("reset dropped write", hrdata[0], 32'h12345678);

    // Randomized traffic on both slaves, including misaligned, oversize and bad-size transfers.
    for (int c = 0; c < 3000; c++) begin
      int r;
      hsel   = 2'($urandom);
      htrans = 2'($urandom);
      hwrite = ($urandom_range(0, 2) == 0);
      hsize  = ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b010;
      r = int'($urandom_range(0, 19));
      if (r == 0)      haddr = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      else if (r == 1) haddr = 32'(DEPTH * 4 + 4 * $urandom_range(0, 1000));
      else if (r == 2) haddr = $urandom | 32'h80000000;
      else             haddr = 32'(4 * $urandom_range(0, DEPTH - 1));
      hready_en = ($urandom_range(0, 9) != 0);
      hwdata    = $urandom;
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
